// File: rtl/pipe_reg_skid_if.sv
// Valid/ready bundle for a pipeline stage register.
// master drives the upstream payload and downstream ready; slave is the stage.
interface pipe_reg_skid_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [1:0]   count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with 2-entry skid buffer and flush.
// Full throughput under backpressure; in_ready comes from state only.
module pipe_reg_skid #(
  parameter int           N       = 32,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_reg_skid_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         acc, drn;

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign bus.count     = state_q;

  assign acc = bus.in_valid & bus.in_ready;
  assign drn = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_d = bus.in_data;
          end else if (acc) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
